// File: rtl/imem_loader.sv
// imem_loader: loads the instruction RAM from a byte stream and holds the
// CPU in reset until loading finishes.
// Stream format: a 16-bit big-endian word count LEN, then LEN*4 data bytes.
// Each group of four data bytes is packed MSB-first and written as one word,
// starting at word address 0.
// Optional build macro IMEM_LOADER_CHECKSUM_EN: one extra byte follows the
// data. It must equal the XOR of every header and data byte. A mismatch sets
// chk_err and keeps the CPU in reset.
module imem_loader #(
    parameter int MEM_DEPTH = 2048,
    parameter int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic              chk_err,
`endif
    output logic              overflow
);

    localparam logic [16:0] DEPTH17 = 17'(MEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_DATA, S_LAST, S_CSUM, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;     // header word count
    logic [15:0]       widx_q, widx_d;   // words fully received this session
    logic [1:0]        bidx_q, bidx_d;   // byte position inside current word
    logic [23:0]       pack_q, pack_d;   // first three bytes of current word
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ovf_q, ovf_d;
    logic              chk_flag;
    logic              xfer;
    state_t            after_data;       // where the last data byte leads
    state_t            after_empty;      // where a zero-length header leads

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;   // running XOR of header+data bytes
    logic              chk_q, chk_d;
    assign chk_flag    = chk_q;
    assign chk_err     = chk_q;
    assign after_data  = S_CSUM;
    assign after_empty = S_CSUM;
`else
    assign chk_flag    = 1'b0;
    assign after_data  = S_LAST;
    assign after_empty = S_DONE;
`endif

    // Handshake readiness is a pure function of state, never of in_valid.
    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            S_HDR0, S_HDR1, S_DATA, S_CSUM: in_ready = 1'b1;
            default:                        in_ready = 1'b0;
        endcase
    end

    assign xfer      = in_valid && in_ready;
    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign cpu_reset = (state_q != S_DONE) || ovf_q || chk_flag;

    // Next-state logic: header capture, word packing and write scheduling.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        pack_d  = pack_q;
        we_d    = 1'b0;
        waddr_d = we_q ? waddr_q + ADDR_W'(1) : waddr_q;
        wdata_d = wdata_q;
        ovf_d   = ovf_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
        chk_d   = chk_q;
        if (xfer && state_q != S_CSUM) csum_d = csum_q ^ in_data;
`endif
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_HDR0;
                    len_d   = '0;
                    widx_d  = '0;
                    bidx_d  = '0;
                    waddr_d = '0;
                    ovf_d   = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d  = '0;
                    chk_d   = 1'b0;
`endif
                end
            end
            S_HDR0: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    state_d     = S_HDR1;
                end
            end
            S_HDR1: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    ovf_d      = {1'b0, len_q[15:8], in_data} > DEPTH17;
                    state_d    = ({len_q[15:8], in_data} == 16'd0) ? after_empty : S_DATA;
                end
            end
            S_DATA: begin
                if (xfer) begin
                    pack_d = {pack_q[15:0], in_data};
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        // Words past the RAM end are consumed but not written.
                        if ({1'b0, widx_q} < DEPTH17) begin
                            we_d    = 1'b1;
                            wdata_d = {pack_q, in_data};
                        end
                        widx_d = widx_q + 16'd1;
                        if (widx_q == len_q - 16'd1) state_d = after_data;
                    end
                end
            end
            S_LAST: state_d = S_DONE;
            S_CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (xfer) begin
                    chk_d   = (in_data != csum_q);
                    state_d = S_DONE;
                end
`else
                state_d = S_DONE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any session in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            pack_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            ovf_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
            chk_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            pack_q  <= pack_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
            chk_q   <= chk_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader. Two instances (depth 2048 and depth 4) receive
// the same byte stream. A reference model derives the expected writes from
// the stream contents and queues them; a monitor pops them on every we pulse.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;

    logic        a_in_ready, a_we, a_cpu_reset, a_busy, a_done, a_overflow;
    logic [10:0] a_waddr;
    logic [31:0] a_wdata;
    logic        b_in_ready, b_we, b_cpu_reset, b_busy, b_done, b_overflow;
    logic [1:0]  b_waddr;
    logic [31:0] b_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic        a_chk_err, b_chk_err;
`endif

    imem_loader #(.MEM_DEPTH(2048)) u_a (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(a_in_ready), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
        .cpu_reset(a_cpu_reset), .busy(a_busy), .done(a_done),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .chk_err(a_chk_err),
`endif
        .overflow(a_overflow)
    );

    imem_loader #(.MEM_DEPTH(4)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(b_in_ready), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
        .cpu_reset(b_cpu_reset), .busy(b_busy), .done(b_done),
`ifdef IMEM_LOADER_CHECKSUM_EN
        .chk_err(b_chk_err),
`endif
        .overflow(b_overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_a[$];
    wr_t         exp_b[$];
    logic [7:0]  pay[$];          // header + data bytes of the next session
    logic        exp_ovf_a, exp_ovf_b, exp_chk;
    int          checks = 0;
    int          errors = 0;
    int          last_wait;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the next expected write.
    always @(negedge clk) begin
        if (a_we === 1'b1) begin
            if (exp_a.size() == 0) check("a_unexpected_we", {53'd0, a_waddr}, 64'hFFFF);
            else begin
                wr_t e;
                e = exp_a.pop_front();
                check("a_write", {21'd0, a_waddr, a_wdata}, {16'd0, e.addr, e.data});
            end
        end
        if (b_we === 1'b1) begin
            if (exp_b.size() == 0) check("b_unexpected_we", {62'd0, b_waddr}, 64'hFFFF);
            else begin
                wr_t e;
                e = exp_b.pop_front();
                check("b_write", {30'd0, b_waddr, b_wdata}, {16'd0, e.addr, e.data});
            end
        end
    end

    // Reference model: words are read from the payload MSB-first, and only
    // indices below the RAM depth are written.
    task automatic build_expect();
        int len;
        len = {pay[0], pay[1]};
        for (int w = 0; w < len; w++) begin
            wr_t e;
            e.addr = 16'(w);
            e.data = {pay[2+4*w], pay[3+4*w], pay[4+4*w], pay[5+4*w]};
            if (w < 2048) exp_a.push_back(e);
            if (w < 4)    exp_b.push_back(e);
        end
        exp_ovf_a = (len > 2048);
        exp_ovf_b = (len > 4);
    endtask

    // mode 0: valid always high; 1: valid on alternate cycles; 2: random
    // valid and random start pulses. csum_val < 0 sends the correct checksum.
    // stop_after >= 0 returns after that many bytes without waiting for done.
    task automatic run_session(input int mode, input int csum_val, input int stop_after);
        logic [7:0] tx[$];
        logic [7:0] x;
        int i, cyc, stalls, rdy_mis;
        bit acc;
        tx = pay;
        x = 8'h00;
        foreach (pay[k]) x ^= pay[k];
        exp_chk = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        tx.push_back(csum_val < 0 ? x : 8'(csum_val));
        exp_chk = (csum_val >= 0) && (8'(csum_val) != x);
`endif
        build_expect();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        i = 0; cyc = 0; stalls = 0; rdy_mis = 0;
        while (i < tx.size() && cyc < 4000) begin
            if (mode == 0)      in_valid = 1'b1;
            else if (mode == 1) in_valid = (cyc % 2 == 0);
            else                in_valid = ($urandom_range(0, 2) != 0);
            in_data = tx[i];
            start = (mode == 2) && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            acc = in_valid && a_in_ready;
            if (a_in_ready !== b_in_ready) rdy_mis++;
            if (in_valid && !a_in_ready) stalls++;
            @(posedge clk); #1;
            if (acc) i++;
            cyc++;
            if (stop_after >= 0 && i == stop_after) break;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("bytes_consumed", 64'(i), stop_after >= 0 ? 64'(stop_after) : 64'(tx.size()));
        check("ready_agree", 64'(rdy_mis), 64'd0);
        if (mode == 0) check("no_stall", 64'(stalls), 64'd0);
        if (stop_after < 0) begin
            last_wait = 0;
            while (!(a_done && b_done) && last_wait < 20) begin
                @(posedge clk); #1;
                last_wait++;
            end
            @(posedge clk); #1;
            check("a_done", a_done, 1'b1);
            check("b_done", b_done, 1'b1);
            check("a_busy", a_busy, 1'b0);
            check("b_busy", b_busy, 1'b0);
            check("a_overflow", a_overflow, exp_ovf_a);
            check("b_overflow", b_overflow, exp_ovf_b);
            check("a_cpu_reset", a_cpu_reset, exp_ovf_a | exp_chk);
            check("b_cpu_reset", b_cpu_reset, exp_ovf_b | exp_chk);
`ifdef IMEM_LOADER_CHECKSUM_EN
            check("a_chk_err", a_chk_err, exp_chk);
            check("b_chk_err", b_chk_err, exp_chk);
`endif
            check("a_missing_writes", 64'(exp_a.size()), 64'd0);
            check("b_missing_writes", 64'(exp_b.size()), 64'd0);
            exp_a.delete();
            exp_b.delete();
        end
    endtask

    task automatic set_fixed();
        pay = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h0A, 8'h20, 8'h09, 8'h00, 8'h14};
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #2;
        check("rst_in_ready", a_in_ready, 1'b0);
        check("rst_we", a_we, 1'b0);
        check("rst_waddr", a_waddr, 11'd0);
        check("rst_wdata", a_wdata, 32'd0);
        check("rst_cpu_reset", a_cpu_reset, 1'b1);
        check("rst_busy_done_ovf", {a_busy, a_done, a_overflow}, 3'b000);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_cpu_reset", a_cpu_reset, 1'b1);

        // Two-word program, full rate, then half rate.
        set_fixed();
        run_session(0, -1, -1);
        set_fixed();
        run_session(1, -1, -1);

        // Empty load.
        pay = '{8'h00, 8'h00};
        run_session(0, -1, -1);
        check("len0_done_latency", 64'(last_wait <= 3), 64'd1);

        // Six words: fits the large instance, overflows the depth-4 one.
        pay = '{8'h00, 8'h06};
        for (int k = 0; k < 24; k++) pay.push_back(8'($urandom));
        run_session(0, -1, -1);

        // Abort after the 5th byte; outputs clear asynchronously.
        set_fixed();
        run_session(0, -1, 5);
        #3 reset_n = 1'b0;
        #1;
        check("abort_busy", a_busy, 1'b0);
        check("abort_cpu_reset", a_cpu_reset, 1'b1);
        check("abort_we", a_we, 1'b0);
        check("abort_in_ready", a_in_ready, 1'b0);
        exp_a.delete();
        exp_b.delete();
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        set_fixed();
        run_session(0, -1, -1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pay = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        run_session(0, 8'h09, -1);
        pay = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
        run_session(0, 8'h00, -1);
`endif

        // Random sessions with random stalls and ignored start pulses.
        for (int s = 0; s < 8; s++) begin
            int len;
            len = $urandom_range(0, 7);
            pay = '{8'h00, 8'(len)};
            for (int k = 0; k < 4 * len; k++) pay.push_back(8'($urandom));
            run_session(2, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
